// File: rtl/dmem_responder.sv
// Data-memory responder with a fixed wait-state latency, so the core's stall path can be exercised.
// Byte/half/word little-endian accesses; misaligned or illegal requests complete with mem_err.
module dmem_responder #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] dAddress,
    input  logic [31:0]       dWriteData,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [31:0]       dReadData,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_count;
    logic              r_isRead;
    logic              r_isWrite;
    logic              r_err;
    logic              r_signExt;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_readData;
    logic              r_ready;
    logic              r_errOut;
    logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

    logic              w_accept;
    logic              w_reqErr;
    logic              w_commit;
    logic [ADDR_W-1:0] w_base;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_loadData;

    assign w_accept = (r_state == IDLE) && (MemRead || MemWrite);
    assign w_commit = (r_state == RESP);
    assign w_reqErr = (size == 2'b11) || (MemRead && MemWrite) ||
                      (size == 2'b01 && dAddress[0]) ||
                      (size == 2'b10 && dAddress[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = (LATENCY > 0) ? WAIT : RESP;
            WAIT: if (r_count <= 4'd1) w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= 4'd0;
            r_isRead  <= 1'b0;
            r_isWrite <= 1'b0;
            r_err     <= 1'b0;
            r_signExt <= 1'b0;
            r_size    <= 2'b00;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
        end else if (w_accept) begin
            r_count   <= LAT4;
            r_isRead  <= MemRead;
            r_isWrite <= MemWrite;
            r_err     <= w_reqErr;
            r_signExt <= sign_ext;
            r_size    <= size;
            r_addr    <= dAddress;
            r_wdata   <= dWriteData;
        end else if (r_state == WAIT) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Aligned accesses stay inside one word, so lanes come from the word base without an adder.
    assign w_base = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_word = {r_mem[w_base | ADDR_W'(3)], r_mem[w_base | ADDR_W'(2)],
                     r_mem[w_base | ADDR_W'(1)], r_mem[w_base]};
    assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_loadData = w_word;
        case (r_size)
            2'b00:   w_loadData = {{24{r_signExt & w_byte[7]}}, w_byte};
            2'b01:   w_loadData = {{16{r_signExt & w_half[15]}}, w_half};
            default: w_loadData = w_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_commit && r_isWrite && !r_err) begin
            case (r_size)
                2'b00: r_mem[r_addr] <= r_wdata[7:0];
                2'b01: begin
                    r_mem[{r_addr[ADDR_W-1:1], 1'b0}] <= r_wdata[7:0];
                    r_mem[{r_addr[ADDR_W-1:1], 1'b1}] <= r_wdata[15:8];
                end
                default: begin
                    r_mem[w_base]              <= r_wdata[7:0];
                    r_mem[w_base | ADDR_W'(1)] <= r_wdata[15:8];
                    r_mem[w_base | ADDR_W'(2)] <= r_wdata[23:16];
                    r_mem[w_base | ADDR_W'(3)] <= r_wdata[31:24];
                end
            endcase
        end
    end

    // Completion is registered out of RESP, so the FSM is already back in IDLE during the pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_readData <= 32'd0;
            r_ready    <= 1'b0;
            r_errOut   <= 1'b0;
        end else begin
            r_ready  <= w_commit;
            r_errOut <= w_commit && r_err;
            if (w_commit && r_err)
                r_readData <= 32'd0;
            else if (w_commit && r_isRead)
                r_readData <= w_loadData;
        end
    end

    assign dReadData = r_readData;
    assign mem_ready = r_ready;
    assign mem_err   = r_errOut;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance (directed + random traffic)
// and a LATENCY=0 instance (back-to-back loads), both checked against a byte-array model.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        rdA = 1'b0, wrA = 1'b0, seA = 1'b0;
    logic [8:0]  addrA = '0;
    logic [31:0] wdA = '0;
    logic [1:0]  sizeA = '0;
    logic [31:0] dataA;
    logic        readyA, errA, busyA;

    logic        rdB = 1'b0, wrB = 1'b0, seB = 1'b0;
    logic [8:0]  addrB = '0;
    logic [31:0] wdB = '0;
    logic [1:0]  sizeB = '0;
    logic [31:0] dataB;
    logic        readyB, errB, busyB;

    int          checks = 0;
    int          errors = 0;
    exp_t        qA[$];
    exp_t        qB[$];
    logic [7:0]  model [2][512];
    logic [31:0] lastRd [2];
    logic        prevA = 1'b0, prevB = 1'b0;

    dmem_responder #(.ADDR_W(9), .LATENCY(LAT_A)) dutA (
        .clk(clk), .rst(rst), .MemRead(rdA), .MemWrite(wrA), .dAddress(addrA),
        .dWriteData(wdA), .size(sizeA), .sign_ext(seA), .dReadData(dataA),
        .mem_ready(readyA), .mem_err(errA), .busy(busyA));

    dmem_responder #(.ADDR_W(9), .LATENCY(LAT_B)) dutB (
        .clk(clk), .rst(rst), .MemRead(rdB), .MemWrite(wrB), .dAddress(addrB),
        .dWriteData(wdB), .size(sizeB), .sign_ext(seB), .dReadData(dataB),
        .mem_ready(readyB), .mem_err(errB), .busy(busyB));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic readyOf(input int inst);
        return (inst == 0) ? readyA : readyB;
    endfunction

    function automatic logic busyOf(input int inst);
        return (inst == 0) ? busyA : busyB;
    endfunction

    // Reference model: a plain byte array plus the last load value each responder should hold.
    task automatic predict(input int inst, input logic rd, input logic wr, input logic [8:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz, input logic se, input bit push);
        exp_t        e;
        int          n;
        logic [31:0] v;
        logic        bad;
        bad = (sz == 2'b11) || (rd && wr) || (sz == 2'b01 && addr[0]) ||
              (sz == 2'b10 && addr[1:0] != 2'b00);
        n = 1 << sz;
        if (bad) begin
            lastRd[inst] = 32'd0;
        end else if (wr) begin
            for (int b = 0; b < n; b++) model[inst][int'(addr) + b] = 8'(wd >> (8 * b));
        end else begin
            v = 32'd0;
            for (int b = 0; b < n; b++) v = v | (32'(model[inst][int'(addr) + b]) << (8 * b));
            if (se && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            lastRd[inst] = v;
        end
        e.data = lastRd[inst];
        e.err  = bad;
        if (push) begin
            if (inst == 0) qA.push_back(e);
            else           qB.push_back(e);
        end
    endtask

    task automatic driveReq(input int inst, input logic rd, input logic wr, input logic [8:0] addr,
                            input logic [31:0] wd, input logic [1:0] sz, input logic se);
        if (inst == 0) begin
            rdA = rd; wrA = wr; addrA = addr; wdA = wd; sizeA = sz; seA = se;
        end else begin
            rdB = rd; wrB = wr; addrB = addr; wdB = wd; sizeB = sz; seB = se;
        end
    endtask

    // Issues one access from a negedge, then checks busy and the accept-to-ready distance.
    task automatic applyStimulus(input int inst, input logic rd, input logic wr, input logic [8:0] addr,
                                 input logic [31:0] wd, input logic [1:0] sz, input logic se);
        int   cnt;
        logic busyOk;
        predict(inst, rd, wr, addr, wd, sz, se, 1'b1);
        driveReq(inst, rd, wr, addr, wd, sz, se);
        @(posedge clk);
        cnt    = 0;
        busyOk = 1'b1;
        forever begin
            @(negedge clk);
            if (readyOf(inst)) break;
            if (!busyOf(inst)) busyOk = 1'b0;
            cnt++;
            if (cnt > 40) break;
        end
        driveReq(inst, 1'b0, 1'b0, addr, wd, sz, se);
        checkOutput("latency", 32'(cnt), 32'((inst == 0 ? LAT_A : LAT_B) + 1));
        checkOutput("busy_while_pending", 32'(busyOk), 32'd1);
        checkOutput("busy_in_ready_cycle", 32'(busyOf(inst)), 32'd0);
    endtask

    // Monitor: pops one expectation per completion pulse, independent of the driver.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (readyA) begin
                if (qA.size() == 0) begin
                    checkOutput("A_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = qA.pop_front();
                    checkOutput("A_dReadData", dataA, e.data);
                    checkOutput("A_mem_err", 32'(errA), 32'(e.err));
                end
            end
            if (readyB) begin
                if (qB.size() == 0) begin
                    checkOutput("B_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = qB.pop_front();
                    checkOutput("B_dReadData", dataB, e.data);
                    checkOutput("B_mem_err", 32'(errB), 32'(e.err));
                end
            end
            if ((readyA && prevA) || (readyB && prevB)) checkOutput("ready_double_pulse", 32'd1, 32'd0);
            if ((errA && !readyA) || (errB && !readyB)) checkOutput("err_without_ready", 32'd1, 32'd0);
        end
        prevA <= readyA;
        prevB <= readyB;
    end

    initial begin
        int   kind;
        int   gap;
        logic [31:0] wordsB [4];
        for (int i = 0; i < 2; i++) begin
            lastRd[i] = 32'd0;
            for (int j = 0; j < 512; j++) model[i][j] = 8'h00;
        end

        // Reset held with requests asserted: nothing may respond.
        driveReq(0, 1'b0, 1'b1, 9'h010, 32'hFFFFFFFF, 2'b10, 1'b0);
        driveReq(1, 1'b1, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("reset_dReadData", dataA, 32'd0);
            checkOutput("reset_mem_ready", 32'(readyA), 32'd0);
            checkOutput("reset_mem_err", 32'(errA), 32'd0);
            checkOutput("reset_busy", 32'(busyA | busyB), 32'd0);
        end
        driveReq(0, 1'b0, 1'b0, 9'h0, 32'h0, 2'b10, 1'b0);
        driveReq(1, 1'b0, 1'b0, 9'h0, 32'h0, 2'b10, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 64; a += 4) applyStimulus(0, 1'b0, 1'b1, 9'(a), 32'd0, 2'b10, 1'b0);

        applyStimulus(0, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 2'b10, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0);
        checkOutput("word_load_value", dataA, 32'hDEADBEEF);

        applyStimulus(0, 1'b0, 1'b1, 9'h013, 32'h00000080, 2'b00, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 9'h013, 32'h0, 2'b00, 1'b1);
        checkOutput("byte_load_sext", dataA, 32'hFFFFFF80);
        applyStimulus(0, 1'b1, 1'b0, 9'h013, 32'h0, 2'b00, 1'b0);
        checkOutput("byte_load_zext", dataA, 32'h00000080);
        applyStimulus(0, 1'b1, 1'b0, 9'h012, 32'h0, 2'b01, 1'b1);
        checkOutput("half_load_sext", dataA, 32'hFFFF80AD);
        applyStimulus(0, 1'b1, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0);
        checkOutput("word_after_byte", dataA, 32'h80ADBEEF);

        applyStimulus(0, 1'b0, 1'b1, 9'h012, 32'h11111111, 2'b10, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0);
        checkOutput("word_after_bad_store", dataA, 32'h80ADBEEF);
        applyStimulus(0, 1'b1, 1'b0, 9'h010, 32'h0, 2'b11, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 9'h014, 32'h22222222, 2'b10, 1'b0);

        // Reset during the second WAIT cycle of a store must abort it.
        @(negedge clk);
        driveReq(0, 1'b0, 1'b1, 9'h020, 32'h12345678, 2'b10, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy_before_abort", 32'(busyA), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("busy_async_drop", 32'(busyA), 32'd0);
        checkOutput("ready_after_abort", 32'(readyA), 32'd0);
        driveReq(0, 1'b0, 1'b0, 9'h020, 32'h0, 2'b10, 1'b0);
        lastRd[0] = 32'd0;
        lastRd[1] = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 9'h020, 32'h0, 2'b10, 1'b0);
        checkOutput("aborted_store_load", dataA, 32'd0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            applyStimulus(0, kind <= 1 ? 1'b1 : (kind >= 5), kind <= 4, 9'($urandom_range(0, 63)),
                          $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Zero-latency instance: fill four words, then stream loads with MemRead held high.
        for (int k = 0; k < 4; k++) begin
            wordsB[k] = $urandom;
            applyStimulus(1, 1'b0, 1'b1, 9'(9'h100 + 4 * k), wordsB[k], 2'b10, 1'b0);
        end
        for (int k = 0; k < 4; k++) predict(1, 1'b1, 1'b0, 9'(9'h100 + 4 * k), 32'h0, 2'b10, 1'b0, 1'b1);
        driveReq(1, 1'b1, 1'b0, 9'h100, 32'h0, 2'b10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!readyB && gap < 20);
            checkOutput("b2b_value", dataB, wordsB[k]);
            if (k > 0) checkOutput("b2b_spacing", 32'(gap), 32'd2);
            if (k < 3) driveReq(1, 1'b1, 1'b0, 9'(9'h100 + 4 * (k + 1)), 32'h0, 2'b10, 1'b0);
            else       driveReq(1, 1'b0, 1'b0, 9'h0, 32'h0, 2'b10, 1'b0);
        end

        repeat (4) @(negedge clk);
        checkOutput("A_queue_drained", 32'(qA.size()), 32'd0);
        checkOutput("B_queue_drained", 32'(qB.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
